zx8x_tape_loader_ctrl: RTL and testbench
========================================

// Module: zx8x_tape_loader_ctrl
// PURPOSE
//  Sequencer for the fast tape-load path. Detects the CPU entering the ROM LOAD routine and takes over memory.
//  - Overlays a 7-byte loop patch on the ROM read data.
//  - Streams the tape buffer into SDRAM at the program base.
//  - Releases the CPU when the buffer is exhausted.
//  Sits between the T80 bus, the tape buffer RAM and the SDRAM write port in the ZX80/ZX81 top level.
// PARAMETERS
//  ZX81_ENTRY  16'h0347  ZX81 LOAD entry address; patch base in ZX81 mode
//  ZX81_EXIT   16'h03C3  first ZX81 address beyond the patched window
//  ZX80_ENTRY  16'h0207  ZX80 LOAD entry address; patch base in ZX80 mode
//  ZX80_EXIT   16'h024D  first ZX80 address beyond the patched window
//  AW          14        tape buffer address width
// PORTS
//  clk_sys     in   1   system clock (52 MHz)
//  reset       in   1   synchronous, active-high reset
//  zx81        in   1   1 = ZX81 ROM/addresses, 0 = ZX80
//  mem64k      in   1   1 = 64k RAM map: SDRAM base 15'h4000, else 15'h0000
//  fmt_p       in   1   1 = .p file (offset +8), 0 = .o file (offset -1)
//  tape_ready  in   1   tape buffer holds a complete image
//  tape_last   in   AW  address of last valid byte in tape buffer
//  ce_cpu_p    in   1   CPU positive clock enable
//  nM1         in   1   CPU M1, active low
//  addr        in   16  CPU address bus
//  ram_ready   in   1   SDRAM write accepted (present only with TAPE_LOADER_RDY_EN)
//  active      out  1   loader owns memory: patch overlay on, CPU RAM reads blocked
//  tape_addr   out  AW  tape buffer read address (buffer read latency 1 clk)
//  ram_addr    out  15  SDRAM write address
//  ram_we      out  1   one-clk SDRAM write strobe
//  patch_dout  out  8   patch byte for (addr - entry)
//  done        out  1   one-clk pulse when the last byte has been written
// BEHAVIOUR
//  Reset values: active=0, tape_addr=0, ram_we=0, done=0, state=IDLE.
//  Reset mid-operation aborts the load immediately; no further writes are issued.
//  M1 edge = nM1 1->0 between consecutive clk_sys samples. All decisions on addr are taken at that edge.
//  States:
//  - IDLE: at M1 edge with tape_ready=1 and addr==ENTRY(zx81) -> COPY.
//    Actions: tape_addr<=0, active<=1, patch[1]<=8'h00 (NOP).
//  - COPY: on ce_cpu_p:
//    - If tape_addr!=tape_last: tape_addr<=tape_addr+1, ram_we<=1 on the next clk.
//    - Else: patch[1]<=8'h37 (SCF), done pulses, -> DONE.
//    - tape_last==0: no write is issued; DONE is entered on the first ce_cpu_p.
//  - DONE: holds active=1 and patch[1]=8'h37 until exit.
//  - Exit (COPY or DONE): at M1 edge with addr>=EXIT or addr<ENTRY -> IDLE, active<=0.
//    Exit takes priority over a simultaneous ce_cpu_p step.
//  - tape_ready=0 in IDLE: entry is never armed. Deassertion during COPY does not abort the load.
//  Patch ROM, offset 0..6:
//    AF, patch[1], 30, FD, C3, lo, 02   where lo = 07 (zx81) / 03 (zx80).
//    Offset >=7 returns 00. Offset = addr - entry, computed mod 2^16 and compared unsigned.
//  ram_addr = base + tape_addr + 8 (fmt_p) or base + tape_addr - 1 (!fmt_p), mod 2^15.
//    Registered together with ram_we, so it pairs with the 1-clk buffer data latency.
//  tape_addr saturates at tape_last and never wraps.
// CONFIGURATION
//  TAPE_LOADER_RDY_EN defined:
//  - Adds the ram_ready port and a WAIT state.
//  - After ram_we, COPY->WAIT; ram_we and ram_addr are held until ram_ready=1, then WAIT->COPY.
//  - ram_ready in the same clk as ram_we counts as accepted.
//  - Exit from WAIT is deferred until the pending write is accepted.
//  Not defined:
//  - Fire-and-forget: at most one write per ce_cpu_p; no ram_ready port.
// TESTING
//  1 zx81=1,mem64k=0,fmt_p=1,tape_last=3, M1 at 0347 -> active=1; 3 writes to 0009,000A,000B; done pulse; patch_dout at 0348 = 37.
//  2 zx81=0, M1 at 0207, addr sweep 0207..020E -> AF,00,30,FD,C3,03,02,00; at 0208 = 37 after done.
//  3 In COPY, M1 at 03C3 (zx81) -> active=0 next clk; no further ram_we.
//  4 tape_ready=0, M1 at 0347 -> active stays 0; tape_last=0 with tape_ready=1 -> done, zero writes.
//  5 reset asserted after 2 of 10 writes -> active=0, tape_addr=0, ram_we=0 next clk; re-entry restarts at tape_addr 0.
//  6 TAPE_LOADER_RDY_EN, ram_ready held 0 for 5 clks -> ram_we/ram_addr held constant; tape_addr advances only after ready.

Source files
------------

// File: rtl/zx8x_tape_loader_ctrl.sv
// zx8x_tape_loader_ctrl: fast tape-load sequencer, ROM LOAD patch overlay plus tape buffer to SDRAM copy
// Optional build macro TAPE_LOADER_RDY_EN adds the ram_ready handshake and a WAIT state.
module zx8x_tape_loader_ctrl #(
   parameter logic [15:0] ZX81_ENTRY = 16'h0347,
   parameter logic [15:0] ZX81_EXIT  = 16'h03C3,
   parameter logic [15:0] ZX80_ENTRY = 16'h0207,
   parameter logic [15:0] ZX80_EXIT  = 16'h024D,
   parameter int          AW         = 14
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          zx81,
   input  logic          mem64k,
   input  logic          fmt_p,
   input  logic          tape_ready,
   input  logic [AW-1:0] tape_last,
   input  logic          ce_cpu_p,
   input  logic          nM1,
   input  logic [15:0]   addr,
`ifdef TAPE_LOADER_RDY_EN
   input  logic          ram_ready,
`endif
   output logic          active,
   output logic [AW-1:0] tape_addr,
   output logic [14:0]   ram_addr,
   output logic          ram_we,
   output logic [7:0]    patch_dout,
   output logic          done
);
   typedef enum logic [1:0] {IDLE, COPY, DONE, WAIT} state_t;
   state_t      state;
   logic        nm1_q, pend, m1_edge, leave;
   logic [7:0]  patch1;
   logic [15:0] entry, exit_a, off;
   logic [14:0] waddr;
`ifdef TAPE_LOADER_RDY_EN
   logic        exit_pend;
`endif
   // Mode-dependent patch window, M1 falling edge, SDRAM target address and patch ROM lookup
   always_comb begin
      entry = zx81 ? ZX81_ENTRY : ZX80_ENTRY;
      exit_a = zx81 ? ZX81_EXIT : ZX80_EXIT;
      off = addr - entry;
      m1_edge = nm1_q & ~nM1;
      leave = m1_edge & ((addr >= exit_a) | (addr < entry));
      waddr = (mem64k ? 15'h4000 : 15'h0000) + 15'(tape_addr) + (fmt_p ? 15'd8 : 15'h7fff);
      patch_dout = off == 16'd0 ? 8'haf :
                   off == 16'd1 ? patch1 :
                   off == 16'd2 ? 8'h30 :
                   off == 16'd3 ? 8'hfd :
                   off == 16'd4 ? 8'hc3 :
                   off == 16'd5 ? (zx81 ? 8'h07 : 8'h03) :
                   off == 16'd6 ? 8'h02 : 8'h00;
   end
   // Loader FSM: enter/leave on M1 edges, one buffer step per CPU enable, write strobe one clk after the step
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state <= IDLE;
         active <= 1'b0;
         tape_addr <= '0;
         ram_addr <= '0;
         ram_we <= 1'b0;
         done <= 1'b0;
         pend <= 1'b0;
         patch1 <= 8'h00;
         nm1_q <= 1'b1;
`ifdef TAPE_LOADER_RDY_EN
         exit_pend <= 1'b0;
`endif
      end else begin
         nm1_q <= nM1;
         done <= 1'b0;
`ifndef TAPE_LOADER_RDY_EN
         ram_we <= 1'b0;
`endif
         if (state == IDLE) begin
            if (m1_edge && tape_ready && addr == entry) begin
               state <= COPY;
               active <= 1'b1;
               tape_addr <= '0;
               patch1 <= 8'h00;
            end
`ifdef TAPE_LOADER_RDY_EN
         end else if (state == WAIT) begin
            if (ram_ready) begin
               ram_we <= 1'b0;
               state <= (exit_pend || leave) ? IDLE : COPY;
               active <= !(exit_pend || leave);
               exit_pend <= 1'b0;
            end else if (leave)
               exit_pend <= 1'b1;
`endif
         end else if (leave) begin
            state <= IDLE;
            active <= 1'b0;
            pend <= 1'b0;
         end else begin
            if (pend) begin
               pend <= 1'b0;
               ram_we <= 1'b1;
               ram_addr <= waddr;
`ifdef TAPE_LOADER_RDY_EN
               state <= WAIT;
`endif
            end
`ifdef TAPE_LOADER_RDY_EN
            if (ce_cpu_p && state == COPY && !pend) begin
`else
            if (ce_cpu_p && state == COPY) begin
`endif
               if (tape_addr < tape_last) begin
                  tape_addr <= tape_addr + AW'(1);
                  pend <= 1'b1;
               end else begin
                  patch1 <= 8'h37;
                  done <= 1'b1;
                  state <= DONE;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_zx8x_tape_loader_ctrl.sv
// tb_zx8x_tape_loader_ctrl: directed bench for the tape loader sequencer
module tb_zx8x_tape_loader_ctrl;
   logic        clk_sys = 1'b0, reset = 1'b1, zx81 = 1'b1, mem64k = 1'b0, fmt_p = 1'b1;
   logic        tape_ready = 1'b1, ce_cpu_p = 1'b0, nM1 = 1'b1;
   logic [13:0] tape_last = 14'd3;
   logic [15:0] addr = 16'h0000;
   logic        active, ram_we, done;
   logic [13:0] tape_addr;
   logic [14:0] ram_addr;
   logic [7:0]  patch_dout;
`ifdef TAPE_LOADER_RDY_EN
   logic        ram_ready = 1'b1;
`endif
   int checks = 0, errors = 0, done_cnt = 0;
   logic [14:0] wr_q[$];

   typedef struct {
      logic        z81;
      logic [15:0] a;
      logic [7:0]  exp;
   } pvec_t;
   pvec_t pv[12];

   always #5 clk_sys = ~clk_sys;

   zx8x_tape_loader_ctrl dut (
      .clk_sys(clk_sys), .reset(reset), .zx81(zx81), .mem64k(mem64k), .fmt_p(fmt_p),
      .tape_ready(tape_ready), .tape_last(tape_last), .ce_cpu_p(ce_cpu_p), .nM1(nM1), .addr(addr),
`ifdef TAPE_LOADER_RDY_EN
      .ram_ready(ram_ready),
`endif
      .active(active), .tape_addr(tape_addr), .ram_addr(ram_addr), .ram_we(ram_we),
      .patch_dout(patch_dout), .done(done)
   );

   // Record accepted SDRAM writes and done pulses mid-cycle
   always @(negedge clk_sys) begin
`ifdef TAPE_LOADER_RDY_EN
      if (ram_we && ram_ready) wr_q.push_back(ram_addr);
`else
      if (ram_we) wr_q.push_back(ram_addr);
`endif
      if (done) done_cnt++;
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic m1_at(input logic [15:0] a);
      addr = a;
      nM1 = 1'b0;
      tick();
      nM1 = 1'b1;
      tick();
   endtask

   task automatic step_ce();
      ce_cpu_p = 1'b1;
      tick();
      ce_cpu_p = 1'b0;
      tick();
      tick();
      tick();
   endtask

   task automatic clear_log();
      wr_q.delete();
      done_cnt = 0;
   endtask

   initial begin
      pv[0]  = '{1'b0, 16'h0207, 8'haf};
      pv[1]  = '{1'b0, 16'h0208, 8'h00};
      pv[2]  = '{1'b0, 16'h0209, 8'h30};
      pv[3]  = '{1'b0, 16'h020A, 8'hfd};
      pv[4]  = '{1'b0, 16'h020B, 8'hc3};
      pv[5]  = '{1'b0, 16'h020C, 8'h03};
      pv[6]  = '{1'b0, 16'h020D, 8'h02};
      pv[7]  = '{1'b0, 16'h020E, 8'h00};
      pv[8]  = '{1'b0, 16'h0206, 8'h00};
      pv[9]  = '{1'b1, 16'h0347, 8'haf};
      pv[10] = '{1'b1, 16'h034C, 8'h07};
      pv[11] = '{1'b1, 16'h034D, 8'h02};

      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk("rst_active", active, 0);
      chk("rst_tape_addr", tape_addr, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_done", done_cnt, 0);

      // zx81 .p load, three bytes
      clear_log();
      m1_at(16'h0347);
      chk("t1_active", active, 1);
      chk("t1_tape_addr0", tape_addr, 0);
      repeat (4) step_ce();
      chk("t1_nwrites", wr_q.size(), 3);
      if (wr_q.size() == 3) begin
         chk("t1_wr0", wr_q[0], 15'h0009);
         chk("t1_wr1", wr_q[1], 15'h000A);
         chk("t1_wr2", wr_q[2], 15'h000B);
      end
      chk("t1_done", done_cnt, 1);
      addr = 16'h0348;
      #1;
      chk("t1_patch1_scf", patch_dout, 8'h37);
      step_ce();
      chk("t1_saturate", tape_addr, 3);
      chk("t1_no_extra_wr", wr_q.size(), 3);
      m1_at(16'h0350);
      chk("t1_in_window_hold", active, 1);
      m1_at(16'h0000);
      chk("t1_exit_below", active, 0);

      // zx80 .o load, 64k map, patch ROM table
      clear_log();
      zx81 = 1'b0; mem64k = 1'b1; fmt_p = 1'b0; tape_last = 14'd2;
      m1_at(16'h0207);
      chk("t2_active", active, 1);
      foreach (pv[i]) begin
         zx81 = pv[i].z81;
         addr = pv[i].a;
         #1;
         chk($sformatf("t2_patch_%0d", i), patch_dout, pv[i].exp);
      end
      zx81 = 1'b0;
      repeat (3) step_ce();
      chk("t2_nwrites", wr_q.size(), 2);
      if (wr_q.size() == 2) begin
         chk("t2_wr0", wr_q[0], 15'h4000);
         chk("t2_wr1", wr_q[1], 15'h4001);
      end
      chk("t2_done", done_cnt, 1);
      addr = 16'h0208;
      #1;
      chk("t2_patch1_scf", patch_dout, 8'h37);
      m1_at(16'h024D);
      chk("t2_exit_at_exit", active, 0);

      // exit mid-copy stops writes
      clear_log();
      zx81 = 1'b1; mem64k = 1'b0; fmt_p = 1'b1; tape_last = 14'd10;
      m1_at(16'h0347);
      repeat (2) step_ce();
      m1_at(16'h03C3);
      chk("t3_exit_active", active, 0);
      repeat (3) step_ce();
      chk("t3_nwrites", wr_q.size(), 2);
      chk("t3_tape_addr", tape_addr, 2);
      chk("t3_no_done", done_cnt, 0);

      // exit wins over a simultaneous step
      clear_log();
      m1_at(16'h0347);
      addr = 16'h03C3;
      nM1 = 1'b0;
      ce_cpu_p = 1'b1;
      tick();
      nM1 = 1'b1;
      ce_cpu_p = 1'b0;
      repeat (3) tick();
      chk("prio_active", active, 0);
      chk("prio_tape_addr", tape_addr, 0);
      chk("prio_nwrites", wr_q.size(), 0);

      // tape not ready, then empty image
      clear_log();
      tape_ready = 1'b0;
      m1_at(16'h0347);
      chk("t4_not_ready", active, 0);
      tape_ready = 1'b1; tape_last = 14'd0;
      m1_at(16'h0347);
      step_ce();
      chk("t4_empty_done", done_cnt, 1);
      chk("t4_empty_nwrites", wr_q.size(), 0);
      chk("t4_empty_active", active, 1);
      m1_at(16'h03C3);

      // reset mid-load with a write pending
      clear_log();
      tape_last = 14'd10;
      m1_at(16'h0347);
      repeat (2) step_ce();
      ce_cpu_p = 1'b1;
      tick();
      ce_cpu_p = 1'b0;
      reset = 1'b1;
      tick();
      chk("t5_rst_active", active, 0);
      chk("t5_rst_tape_addr", tape_addr, 0);
      chk("t5_rst_ram_we", ram_we, 0);
      reset = 1'b0;
      repeat (3) tick();
      chk("t5_nwrites", wr_q.size(), 2);
      clear_log();
      m1_at(16'h0347);
      chk("t5_reentry_addr", tape_addr, 0);
      step_ce();
      chk("t5_reentry_nwr", wr_q.size(), 1);
      if (wr_q.size() == 1) chk("t5_reentry_wr", wr_q[0], 15'h0009);
      m1_at(16'h0000);

`ifdef TAPE_LOADER_RDY_EN
      // write held until the SDRAM accepts it
      clear_log();
      ram_ready = 1'b0;
      m1_at(16'h0347);
      ce_cpu_p = 1'b1;
      tick();
      ce_cpu_p = 1'b0;
      tick();
      chk("t6_we", ram_we, 1);
      chk("t6_addr", ram_addr, 15'h0009);
      for (int k = 0; k < 5; k++) begin
         ce_cpu_p = (k == 2);
         tick();
         chk($sformatf("t6_hold_we_%0d", k), ram_we, 1);
         chk($sformatf("t6_hold_addr_%0d", k), ram_addr, 15'h0009);
         chk($sformatf("t6_hold_ta_%0d", k), tape_addr, 1);
      end
      ce_cpu_p = 1'b0;
      ram_ready = 1'b1;
      tick();
      chk("t6_release", ram_we, 0);
      chk("t6_one_write", wr_q.size(), 1);
      step_ce();
      chk("t6_advance", tape_addr, 2);
      m1_at(16'h0000);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
